bcd_serial_add_ctrl: RTL and testbench

Digit-serial controller for a multi-digit BCD adder. The block accepts two packed BCD operands and a carry-in on a single start strobe. It then sequences one shared single-digit BCD add stage across all digits, least-significant first, one digit per clock. It presents the packed BCD sum, carry-out and an invalid-digit flag with a one-cycle done pulse. It replaces the fully parallel cascaded digit adders where area matters more than latency, and it sits between operand registers and the display/result path.

---
 rtl/bcd_serial_add_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder controller: one shared digit-add stage is stepped
// across DIGITS packed BCD digits, least-significant first, one per clock.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [W-1:0]     DIG_MASK = W'(4'hF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Single-digit BCD add: {carry, digit}; out-of-range digits still follow the +6 rule.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] da, input logic [3:0] db,
                                               input logic ci);
    logic [4:0] raw;
    logic [4:0] adj;
    raw = {1'b0, da} + {1'b0, db} + {4'b0000, ci};
    adj = raw + 5'd6;
    if (raw > 5'd9) begin
      return {1'b1, adj[3:0]};
    end else begin
      return {1'b0, raw[3:0]};
    end
  endfunction

  function automatic logic digit_invalid(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     work_r;
  logic             carry_r;
  logic             err_int_r;
  logic [IDX_W-1:0] idx_r;
  logic             busy_r;
  logic             done_r;
  logic [W-1:0]     sum_r;
  logic             cout_r;
  logic             err_r;

  logic             accept_s;
  logic             last_s;
  logic [IDX_W+1:0] shamt_s;
  logic [W-1:0]     a_shift_s;
  logic [W-1:0]     b_shift_s;
  logic [3:0]       a_dig_s;
  logic [3:0]       b_dig_s;
  logic [4:0]       add_s;
  logic [W-1:0]     work_next_s;
  logic             err_next_s;

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    last_s       = (idx_r == LAST_IDX);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Current-digit datapath: select digit idx, add, and merge into the working result.
  always_comb begin
    shamt_s     = {idx_r, 2'b00};
    a_shift_s   = a_r >> shamt_s;
    b_shift_s   = b_r >> shamt_s;
    a_dig_s     = a_shift_s[3:0];
    b_dig_s     = b_shift_s[3:0];
    add_s       = bcd_digit_add(a_dig_s, b_dig_s, carry_r);
    work_next_s = (work_r & ~(DIG_MASK << shamt_s)) | (W'(add_s[3:0]) << shamt_s);
    err_next_s  = err_int_r | digit_invalid(a_dig_s) | digit_invalid(b_dig_s);
  end

  // Operand latches, digit index, working result, running carry and sticky error.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      work_r    <= '0;
      carry_r   <= 1'b0;
      err_int_r <= 1'b0;
      idx_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r       <= a;
            b_r       <= b;
            carry_r   <= cin;
            work_r    <= '0;
            err_int_r <= 1'b0;
            idx_r     <= '0;
          end
        end
        ST_RUN: begin
          work_r    <= work_next_s;
          carry_r   <= add_s[4];
          err_int_r <= err_next_s;
          if (!last_s) begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_DONE: idx_r <= '0;
        default: idx_r <= '0;
      endcase
    end
  end

  // Registered outputs; the result is captured on the edge that enters DONE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
      done_r <= (state_next_s == ST_DONE);
      if ((state_r == ST_RUN) && last_s) begin
        sum_r  <= work_next_s;
        cout_r <= add_s[4];
        err_r  <= err_next_s;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign err  = err_r;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Randomized self-checking bench for bcd_serial_add_ctrl against a decimal
// reference model (per-digit rule only when a digit is out of BCD range).
module tb_bcd_serial_add_ctrl;

  localparam int D = 3;
  localparam int W = 4 * D;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int passed = 0;
  int total  = 0;

  logic [W-1:0] prev_sum  = '0;
  logic         prev_cout = 1'b0;
  logic         prev_err  = 1'b0;

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
    .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Valid operands: add as decimal numbers. Otherwise apply the digit rule directly.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                                output logic [W-1:0] s, output logic co, output logic e);
    int va = 0, vb = 0, lim = 1, tot, carry, raw;
    bit inv = 0;
    s = '0;
    for (int i = D - 1; i >= 0; i--) begin
      if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) inv = 1;
      va = va * 10 + int'(ma[4*i +: 4]);
      vb = vb * 10 + int'(mb[4*i +: 4]);
      lim = lim * 10;
    end
    e = inv;
    if (!inv) begin
      tot = va + vb + int'(mc);
      co = (tot >= lim);
      tot = tot % lim;
      for (int i = 0; i < D; i++) begin
        s[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      carry = int'(mc);
      for (int i = 0; i < D; i++) begin
        raw = int'(ma[4*i +: 4]) + int'(mb[4*i +: 4]) + carry;
        if (raw > 9) begin
          s[4*i +: 4] = 4'((raw + 6) % 16);
          carry = 1;
        end else begin
          s[4*i +: 4] = 4'(raw);
          carry = 0;
        end
      end
      co = carry[0];
    end
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < D; i++)
      v[4*i +: 4] = allow_bad ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Called at a negedge while idle; returns at the negedge of the following idle cycle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_in, input logic tc,
                        input bit scramble, input int stray_at);
    logic [W-1:0] es;
    logic eco, ee;
    bit got = 0;
    int cyc = 0;
    model(ta, tb_in, tc, es, eco, ee);
    a = ta; b = tb_in; cin = tc; start = 1'b1;
    @(posedge sys_clk);
    while (!got && cyc < 20) begin
      @(negedge sys_clk);
      cyc++;
      if (done) begin
        got = 1;
        check("latency", 64'(cyc), 64'(D + 1));
        check("sum", 64'(sum), 64'(es));
        check("cout", 64'(cout), 64'(eco));
        check("err", 64'(err), 64'(ee));
        check("busy_done", 64'(busy), 64'd1);
      end else begin
        check("busy_run", 64'(busy), 64'd1);
        check("sum_hold", 64'(sum), 64'(prev_sum));
      end
      start = (cyc == stray_at);
      if (scramble || cyc == stray_at) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
    end
    start = 1'b0;
    if (!got) check("done_timeout", 64'd0, 64'd1);
    prev_sum = es; prev_cout = eco; prev_err = ee;
    @(negedge sys_clk);
    check("idle_done", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      check("no_done", 64'(done), 64'd0);
      check("no_busy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    repeat (2) @(negedge sys_clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    run_op(12'h999, 12'h001, 1'b0, 0, -1);
    run_op(12'h123, 12'h456, 1'b0, 0, -1);
    run_op(12'h058, 12'h047, 1'b1, 0, -1);
    // Stray start during RUN is dropped; back-to-back op starts at cycle D+2.
    run_op(12'h321, 12'h111, 1'b0, 0, 2);
    run_op(12'h500, 12'h500, 1'b1, 0, -1);
    idle_check(4);
    run_op(12'h00A, 12'h000, 1'b0, 0, -1);
    run_op(12'h010, 12'h020, 1'b0, 0, -1);
    run_op(12'h888, 12'h111, 1'b1, 1, -1);

    // Reset in RUN cycle 2: outputs clear at once and the op never completes.
    a = 12'h444; b = 12'h555; cin = 1'b0; start = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    start = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_sum", 64'(sum), 64'd0);
    check("mid_rst_cout", 64'(cout), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    prev_sum = '0; prev_cout = 1'b0; prev_err = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle_check(6);
    run_op(12'h246, 12'h135, 1'b1, 0, -1);

    for (int k = 0; k < 40; k++)
      run_op(rand_bcd(($urandom_range(0, 4) == 0)), rand_bcd(($urandom_range(0, 4) == 0)),
             1'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0) ? 2 : -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
